// File: rtl/bitstream_load_pkg.sv
// Shared constants for the bitstream loader: FSM encodings, default sync bytes,
// error codes and header geometry.
package bitstream_load_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SYNC1 = 3'd1;
    localparam logic [2:0] ST_LEN   = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_CSUM  = 3'd4;
    localparam logic [2:0] ST_DRAIN = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;
    localparam logic [2:0] ST_ERROR = 3'd7;

    localparam logic [7:0] DEF_SYNC0 = 8'hA5;
    localparam logic [7:0] DEF_SYNC1 = 8'h5A;

    localparam int LEN_BYTES = 3;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_TIMEOUT  = 3'd1,
        ERR_BAD_LEN  = 3'd2,
        ERR_OVERFLOW = 3'd3,
        ERR_CHECKSUM = 3'd4
    } err_code_e;

endpackage

// File: rtl/bitstream_load_ctrl_packer.sv
// Packs payload bytes big-endian into 32-bit words and holds each word in an
// output register until the config writer accepts it.
module cfg_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    input  logic        cfg_ready,
    output logic [31:0] cfg_data,
    output logic        cfg_valid,
    output logic        word_done,
    output logic        accept,
    output logic        overflow
);

    logic [23:0] pack_q;
    logic [1:0]  cnt_q;

    assign word_done = byte_valid && (cnt_q == 2'd3);
    assign accept    = cfg_valid && cfg_ready;
    // A finished word with the previous one still stalled has nowhere to go.
    assign overflow  = word_done && cfg_valid && !cfg_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q    <= '0;
            cnt_q     <= '0;
            cfg_data  <= '0;
            cfg_valid <= 1'b0;
        end else if (flush) begin
            pack_q    <= '0;
            cnt_q     <= '0;
            cfg_data  <= '0;
            cfg_valid <= 1'b0;
        end else begin
            if (byte_valid) begin
                pack_q <= {pack_q[15:0], byte_data};
                cnt_q  <= cnt_q + 2'd1;
            end
            if (word_done && !overflow) begin
                cfg_data  <= {pack_q, byte_data};
                cfg_valid <= 1'b1;
            end else if (accept) begin
                cfg_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bitstream_load_ctrl.sv
// Bitstream download sequencer: sync hunt, length header, payload packing,
// checksum verification and sticky done/error status.
module bitstream_load_ctrl
    import bitstream_load_pkg::*;
#(
    parameter int         MAX_WORDS      = 25000,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] SYNC0          = DEF_SYNC0,
    parameter logic [7:0] SYNC1          = DEF_SYNC1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        clear,
    output logic [31:0] cfg_data,
    output logic        cfg_valid,
    input  logic        cfg_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  err_code,
    output logic [23:0] word_count,
    output logic [2:0]  dbg_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]  state_q, state_next;
    logic [1:0]  len_cnt_q;
    logic [23:0] len_q;
    logic [23:0] len_full;
    logic [23:0] words_packed_q;
    logic [7:0]  sum_q;
    logic [7:0]  csum_total;
    logic [TW-1:0] timer_q;
    err_code_e   err_q;
    err_code_e   err_val;
    logic        err_set;
    logic        timed;
    logic        timeout_hit;
    logic        data_byte;
    logic        flush;
    logic        word_done;
    logic        accept;
    logic        overflow;

    assign len_full   = {len_q[15:0], rx_data};
    assign csum_total = sum_q + rx_data;
    assign timed      = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    // An arriving byte always beats timer expiry in the same cycle.
    assign timeout_hit = timed && !rx_valid && (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign data_byte   = rx_valid && !clear && (state_q == ST_DATA);
    assign flush       = clear || err_set || (state_q == ST_ERROR);

    cfg_word_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .byte_data (rx_data),
        .byte_valid(data_byte),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .word_done (word_done),
        .accept    (accept),
        .overflow  (overflow)
    );

    always_comb begin
        state_next = state_q;
        err_set    = 1'b0;
        err_val    = ERR_NONE;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid && rx_data == SYNC0) state_next = ST_SYNC1;
            end
            ST_SYNC1: begin
                if (rx_valid) begin
                    if (rx_data == SYNC1)      state_next = ST_LEN;
                    else if (rx_data != SYNC0) state_next = ST_IDLE;
                end
            end
            ST_LEN: begin
                if (rx_valid && len_cnt_q == 2'(LEN_BYTES - 1)) begin
                    if (len_full == '0 || len_full > 24'(MAX_WORDS)) begin
                        state_next = ST_ERROR;
                        err_set    = 1'b1;
                        err_val    = ERR_BAD_LEN;
                    end else begin
                        state_next = ST_DATA;
                    end
                end else if (timeout_hit) begin
                    state_next = ST_ERROR;
                    err_set    = 1'b1;
                    err_val    = ERR_TIMEOUT;
                end
            end
            ST_DATA: begin
                if (overflow) begin
                    state_next = ST_ERROR;
                    err_set    = 1'b1;
                    err_val    = ERR_OVERFLOW;
                end else if (word_done && words_packed_q == len_q - 24'd1) begin
                    state_next = ST_CSUM;
                end else if (timeout_hit) begin
                    state_next = ST_ERROR;
                    err_set    = 1'b1;
                    err_val    = ERR_TIMEOUT;
                end
            end
            ST_CSUM: begin
                if (rx_valid) begin
                    if (csum_total == 8'd0) begin
                        state_next = ST_DRAIN;
                    end else begin
                        state_next = ST_ERROR;
                        err_set    = 1'b1;
                        err_val    = ERR_CHECKSUM;
                    end
                end else if (timeout_hit) begin
                    state_next = ST_ERROR;
                    err_set    = 1'b1;
                    err_val    = ERR_TIMEOUT;
                end
            end
            ST_DRAIN: begin
                if (!cfg_valid || accept) state_next = ST_DONE;
            end
            default: ;
        endcase
        if (clear) begin
            state_next = ST_IDLE;
            err_set    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            len_cnt_q      <= '0;
            len_q          <= '0;
            words_packed_q <= '0;
            sum_q          <= '0;
            timer_q        <= '0;
            err_q          <= ERR_NONE;
            word_count     <= '0;
        end else begin
            state_q <= state_next;
            if (rx_valid || (state_next != state_q) || !timed) timer_q <= '0;
            else                                                timer_q <= timer_q + TW'(1);
            if (clear) begin
                len_cnt_q      <= '0;
                len_q          <= '0;
                words_packed_q <= '0;
                sum_q          <= '0;
                err_q          <= ERR_NONE;
                word_count     <= '0;
            end else begin
                if (err_set) err_q <= err_val;
                if (accept)  word_count <= word_count + 24'd1;
                case (state_q)
                    ST_IDLE: begin
                        len_cnt_q      <= '0;
                        words_packed_q <= '0;
                        sum_q          <= '0;
                    end
                    ST_LEN: begin
                        if (rx_valid) begin
                            len_q     <= len_full;
                            len_cnt_q <= len_cnt_q + 2'd1;
                        end
                    end
                    ST_DATA: begin
                        if (rx_valid)  sum_q <= csum_total;
                        if (word_done) words_packed_q <= words_packed_q + 24'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy      = !((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR));
    assign done      = (state_q == ST_DONE);
    assign error     = (state_q == ST_ERROR);
    assign err_code  = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bitstream_load_ctrl.sv
// Directed bench for bitstream_load_ctrl: nominal, checksum, backpressure,
// length, sync hunting, timeout and abort scenarios.
module tb_bitstream_load_ctrl;
    import bitstream_load_pkg::*;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] cfg_data;
    logic        cfg_valid;
    logic        cfg_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  err_code;
    logic [23:0] word_count;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [7:0]  stream[$];

    bitstream_load_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .clear(clear), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .word_count(word_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Inputs only move 1ns after a rising edge, so a handshake seen here completes next edge.
    always @(negedge clk) begin
        if (rst_n && cfg_valid && cfg_ready) got_q.push_back(cfg_data);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_stream();
        foreach (stream[i]) send_byte(stream[i]);
        stream.delete();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic check_words(input string tag);
        check({tag, "_nwords"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            check({tag, "_word"}, got_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick();
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_cfg_data", cfg_data, 32'h0);
        check("rst_cfg_valid", cfg_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_err_code", err_code, 3'd0);
        check("rst_word_count", word_count, 24'd0);

        // Nominal two-word load
        stream = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
                   8'h05, 8'h06, 8'h07, 8'h08, 8'hDC};
        exp_q = '{32'h01020304, 32'h05060708};
        send_stream();
        tick(3);
        check("nom_done", done, 1'b1);
        check("nom_error", error, 1'b0);
        check("nom_err_code", err_code, 3'd0);
        check("nom_word_count", word_count, 24'd2);
        check("nom_busy", busy, 1'b0);
        check_words("nom");
        send_byte(8'hA5);
        check("done_ignores_rx", dbg_state, ST_DONE);
        do_clear();
        check("clr_done", done, 1'b0);
        check("clr_word_count", word_count, 24'd0);

        // Bad checksum
        stream = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
                   8'h05, 8'h06, 8'h07, 8'h08, 8'hDD};
        exp_q = '{32'h01020304, 32'h05060708};
        send_stream();
        tick(3);
        check("csum_error", error, 1'b1);
        check("csum_err_code", err_code, 3'd4);
        check("csum_done", done, 1'b0);
        check("csum_word_count", word_count, 24'd2);
        check_words("csum");
        do_clear();
        check("clr_error", error, 1'b0);
        check("clr_err_code", err_code, 3'd0);

        // Backpressure held: second word overflows
        cfg_ready = 1'b0;
        stream = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04};
        send_stream();
        tick();
        check("bp_valid_w1", cfg_valid, 1'b1);
        check("bp_data_w1", cfg_data, 32'h01020304);
        stream = '{8'h05, 8'h06, 8'h07, 8'h08};
        send_stream();
        check("ovf_error", error, 1'b1);
        check("ovf_err_code", err_code, 3'd3);
        check("ovf_cfg_valid", cfg_valid, 1'b0);
        check("ovf_word_count", word_count, 24'd0);
        check_words("ovf");
        do_clear();

        // Backpressure pulsed after word 1, final word drained
        stream = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04};
        exp_q = '{32'h01020304, 32'h05060708};
        send_stream();
        tick();
        cfg_ready = 1'b1;
        tick();
        cfg_ready = 1'b0;
        check("pulse_wc1", word_count, 24'd1);
        stream = '{8'h05, 8'h06, 8'h07, 8'h08, 8'hDC};
        send_stream();
        tick(2);
        check("drain_state", dbg_state, ST_DRAIN);
        check("drain_busy", busy, 1'b1);
        check("drain_valid", cfg_valid, 1'b1);
        cfg_ready = 1'b1;
        tick(2);
        check("pulse_done", done, 1'b1);
        check("pulse_word_count", word_count, 24'd2);
        check_words("pulse");
        do_clear();

        // Length checks
        stream = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00};
        send_stream();
        check("len0_err_code", err_code, 3'd2);
        check("len0_error", error, 1'b1);
        do_clear();
        stream = '{8'hA5, 8'h5A, 8'h00, 8'h61, 8'hA9};
        send_stream();
        check("lenmax1_err_code", err_code, 3'd2);
        do_clear();
        stream = '{8'hA5, 8'h5A, 8'h00, 8'h61, 8'hA8};
        send_stream();
        check("lenmax_state", dbg_state, ST_DATA);
        check("lenmax_error", error, 1'b0);
        do_clear();

        // Sync hunting with a repeated first sync byte
        stream = '{8'h00, 8'hA5, 8'hA5, 8'h5A, 8'h00, 8'h00, 8'h01,
                   8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hF2};
        exp_q = '{32'hAABBCCDD};
        send_stream();
        tick(3);
        check("hunt_done", done, 1'b1);
        check("hunt_word_count", word_count, 24'd1);
        check_words("hunt");
        do_clear();
        stream = '{8'hA5, 8'h33};
        send_stream();
        check("hunt_reject_state", dbg_state, ST_IDLE);

        // Byte arriving on the expiry cycle keeps the load alive
        stream = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h01};
        send_stream();
        tick(TMO - 1);
        check("tmo_edge_state", dbg_state, ST_DATA);
        send_byte(8'h11);
        check("tmo_byte_wins", error, 1'b0);
        do_clear();

        // Stall after the length bytes
        stream = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h01};
        send_stream();
        tick(TMO - 1);
        check("tmo_pre_error", error, 1'b0);
        tick();
        check("tmo_error", error, 1'b1);
        check("tmo_err_code", err_code, 3'd1);
        do_clear();

        // Abort mid-DATA, then a clean load
        stream = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        exp_q = '{32'h01020304};
        send_stream();
        check("abort_pre_wc", word_count, 24'd1);
        do_clear();
        check("abort_state", dbg_state, ST_IDLE);
        check("abort_busy", busy, 1'b0);
        check("abort_error", error, 1'b0);
        check("abort_word_count", word_count, 24'd0);
        check("abort_cfg_valid", cfg_valid, 1'b0);
        check_words("abort");
        stream = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
                   8'h05, 8'h06, 8'h07, 8'h08, 8'hDC};
        exp_q = '{32'h01020304, 32'h05060708};
        send_stream();
        tick(3);
        check("reload_done", done, 1'b1);
        check("reload_err_code", err_code, 3'd0);
        check("reload_word_count", word_count, 24'd2);
        check_words("reload");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
